// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_pkg
//  Description : Shared types and defaults for the read-ID remapping path.
//                These are used by the AR ingress stage, the ID allocator and
//                the R-path restore stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

   localparam int ROB_ID_WIDTH  = 4;
   localparam int ROB_PAYLOAD_W = 64;

   // The AR beat waits in HOLD with its original ID until an ID is allocated.
   typedef struct packed {
      logic [ROB_ID_WIDTH-1:0]  id;
      logic [ROB_PAYLOAD_W-1:0] payload;
   } ar_hold_t;

   // The AR beat sits in OUT with its allocated unique ID.
   typedef struct packed {
      logic [ROB_ID_WIDTH-1:0]  uid;
      logic [ROB_PAYLOAD_W-1:0] payload;
   } ar_out_t;

endpackage : rob_pkg
`default_nettype wire

// File: rtl/rob_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_pipe_reg
//  Description : Valid/data pipeline register. Load has priority over clear,
//                so a simultaneous drain and refill replaces the contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;

   // Next state: a load sets valid and captures data, a clear only drops valid.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule : rob_pipe_reg
`default_nettype wire

// File: rtl/ar_id_remapper.sv
`default_nettype none
// ============================================================================
//  Module      : ar_id_remapper
//  Description : AR ingress stage. It holds each incoming AR beat, requests a
//                unique ID for the beat's original ARID, and forwards the beat
//                downstream with ARID replaced by the granted unique ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module ar_id_remapper
   import rob_pkg::*;
#(
   parameter int ID_WIDTH    = ROB_ID_WIDTH,
   parameter int PAYLOAD_W   = ROB_PAYLOAD_W,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   // upstream AR
   input  logic                   s_arvalid,
   output logic                   s_arready,
   input  logic [ID_WIDTH-1:0]    s_arid,
   input  logic [PAYLOAD_W-1:0]   s_arpayload,
   // allocator
   output logic                   alloc_req,
   output logic [ID_WIDTH-1:0]    alloc_orig_id,
   input  logic                   alloc_gnt,
   input  logic [ID_WIDTH-1:0]    alloc_unique_id,
   input  logic                   alloc_full,
   // downstream AR
   output logic                   m_arvalid,
   input  logic                   m_arready,
   output logic [ID_WIDTH-1:0]    m_arid,
   output logic [PAYLOAD_W-1:0]   m_arpayload,
   // status
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int ENTRY_W = ID_WIDTH + PAYLOAD_W;

   logic                   w_hold_valid;
   logic [ENTRY_W-1:0]     w_hold_data;
   logic [ID_WIDTH-1:0]    w_hold_id;
   logic [PAYLOAD_W-1:0]   w_hold_payload;
   logic [ENTRY_W-1:0]     w_out_data;
   logic                   w_out_can_load;
   logic                   w_grant;
   logic                   w_s_hs;
   logic                   w_unused_alloc_full;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   // The allocator's full flag is status only; its grant is authoritative.
   assign w_unused_alloc_full = alloc_full;

   assign w_hold_id      = w_hold_data[ENTRY_W-1 -: ID_WIDTH];
   assign w_hold_payload = w_hold_data[PAYLOAD_W-1:0];

   // Handshake glue. The request never looks at the grant, which avoids a
   // combinational loop through the allocator. The grant is qualified with
   // the request so a stray grant cannot retire a beat OUT cannot store.
   assign w_out_can_load = ~m_arvalid | m_arready;
   assign alloc_req      = w_hold_valid & w_out_can_load;
   assign alloc_orig_id  = w_hold_id;
   assign w_grant        = alloc_req & alloc_gnt;
   assign s_arready      = ~w_hold_valid | w_grant;
   assign w_s_hs         = s_arvalid & s_arready;

   rob_pipe_reg #(
      .WIDTH   (ENTRY_W)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load_i  (w_s_hs),
      .clear_i (w_grant),
      .data_i  ({s_arid, s_arpayload}),
      .valid_o (w_hold_valid),
      .data_o  (w_hold_data)
   );

   rob_pipe_reg #(
      .WIDTH   (ENTRY_W)
   ) u_out (
      .clk     (clk),
      .rst     (rst),
      .load_i  (w_grant),
      .clear_i (m_arready),
      .data_i  ({alloc_unique_id, w_hold_payload}),
      .valid_o (m_arvalid),
      .data_o  (w_out_data)
   );

   assign m_arid      = w_out_data[ENTRY_W-1 -: ID_WIDTH];
   assign m_arpayload = w_out_data[PAYLOAD_W-1:0];

   // The stall counter advances on every requested-but-refused cycle and sticks at all-ones.
   always_comb begin
      stall_d = stall_q;
      if (alloc_req && !alloc_gnt && !(&stall_q)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

endmodule : ar_id_remapper
`default_nettype wire

// File: tb/tb_ar_id_remapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ar_id_remapper
//  Description : Directed self-checking bench for ar_id_remapper. A small
//                allocator model grants sequential unique IDs unless blocked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ar_id_remapper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [3:0]  s_arid = '0;
   logic [63:0] s_arpayload = '0;
   logic        alloc_req;
   logic [3:0]  alloc_orig_id;
   logic        alloc_gnt;
   logic [3:0]  alloc_unique_id;
   logic        alloc_full = 1'b0;
   logic        m_arvalid;
   logic        m_arready = 1'b0;
   logic [3:0]  m_arid;
   logic [63:0] m_arpayload;
   logic [15:0] stall_cycles;

   // narrow-counter instance outputs
   logic        n_s_arready, n_alloc_req, n_m_arvalid;
   logic [3:0]  n_alloc_orig_id, n_m_arid;
   logic [63:0] n_m_arpayload;
   logic [3:0]  n_stall_cycles;
   logic        n_alloc_gnt;

   // allocator model
   logic        alloc_block = 1'b0;
   logic [3:0]  next_uid;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign alloc_gnt       = alloc_req & ~alloc_block;
   assign alloc_unique_id = next_uid;
   assign n_alloc_gnt     = n_alloc_req & ~alloc_block;

   always @(posedge clk) begin
      if (rst)            next_uid <= 4'h0;
      else if (alloc_gnt) next_uid <= next_uid + 4'h1;
   end

   ar_id_remapper #(.ID_WIDTH(4), .PAYLOAD_W(64), .STALL_CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_arpayload(s_arpayload),
      .alloc_req(alloc_req), .alloc_orig_id(alloc_orig_id), .alloc_gnt(alloc_gnt),
      .alloc_unique_id(alloc_unique_id), .alloc_full(alloc_full),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_arpayload(m_arpayload),
      .stall_cycles(stall_cycles)
   );

   ar_id_remapper #(.ID_WIDTH(4), .PAYLOAD_W(64), .STALL_CNT_W(4)) dut_narrow (
      .clk(clk), .rst(rst),
      .s_arvalid(s_arvalid), .s_arready(n_s_arready), .s_arid(s_arid), .s_arpayload(s_arpayload),
      .alloc_req(n_alloc_req), .alloc_orig_id(n_alloc_orig_id), .alloc_gnt(n_alloc_gnt),
      .alloc_unique_id(alloc_unique_id), .alloc_full(alloc_full),
      .m_arvalid(n_m_arvalid), .m_arready(m_arready), .m_arid(n_m_arid), .m_arpayload(n_m_arpayload),
      .stall_cycles(n_stall_cycles)
   );

   typedef struct {
      logic [3:0]  arid;
      logic [63:0] payload;
      logic [3:0]  exp_uid;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{4'h5, 64'h0123_4567_89AB_CDE0, 4'h0};
      vecs[1] = '{4'h5, 64'hFEDC_BA98_7654_3211, 4'h1};
      vecs[2] = '{4'h5, 64'hA5A5_A5A5_5A5A_5A52, 4'h2};
      vecs[3] = '{4'h5, 64'h0000_0000_0000_0003, 4'h3};
      vecs[4] = '{4'h5, 64'hFFFF_FFFF_FFFF_FFF4, 4'h4};
      vecs[5] = '{4'h5, 64'hDEAD_BEEF_CAFE_F005, 4'h5};
      vecs[6] = '{4'h5, 64'h8000_0000_0000_0006, 4'h6};
      vecs[7] = '{4'h5, 64'h1357_9BDF_2468_ACE7, 4'h7};

      // ---------------- reset state ----------------
      do_reset();
      check("rst_m_arvalid", {63'd0, m_arvalid}, 64'd0);
      check("rst_m_arid", {60'd0, m_arid}, 64'd0);
      check("rst_m_arpayload", m_arpayload, 64'd0);
      check("rst_s_arready", {63'd0, s_arready}, 64'd1);
      check("rst_alloc_req", {63'd0, alloc_req}, 64'd0);
      check("rst_stall", {48'd0, stall_cycles}, 64'd0);

      // ---------------- single beat ----------------
      s_arvalid = 1'b1; s_arid = 4'h3; s_arpayload = 64'hC0FF_EE00_1234_5678;
      tick();
      s_arvalid = 1'b0;
      check("single_alloc_req", {63'd0, alloc_req}, 64'd1);
      check("single_orig_id", {60'd0, alloc_orig_id}, 64'd3);
      check("single_m_arvalid_pre", {63'd0, m_arvalid}, 64'd0);
      tick();
      check("single_m_arvalid", {63'd0, m_arvalid}, 64'd1);
      check("single_m_arid", {60'd0, m_arid}, 64'd0);
      check("single_payload", m_arpayload, 64'hC0FF_EE00_1234_5678);
      check("single_req_idle", {63'd0, alloc_req}, 64'd0);
      m_arready = 1'b1;
      tick();
      check("single_drained", {63'd0, m_arvalid}, 64'd0);

      // ---------------- stream of 8 beats ----------------
      do_reset();
      m_arready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_arvalid = 1'b1; s_arid = vecs[i].arid; s_arpayload = vecs[i].payload;
         #1;
         check($sformatf("stream_s_arready[%0d]", i), {63'd0, s_arready}, 64'd1);
         tick();
         if (i > 0) begin
            check($sformatf("stream_valid[%0d]", i - 1), {63'd0, m_arvalid}, 64'd1);
            check($sformatf("stream_arid[%0d]", i - 1), {60'd0, m_arid}, {60'd0, vecs[i - 1].exp_uid});
            check($sformatf("stream_payload[%0d]", i - 1), m_arpayload, vecs[i - 1].payload);
         end
      end
      s_arvalid = 1'b0;
      tick();
      check("stream_valid[7]", {63'd0, m_arvalid}, 64'd1);
      check("stream_arid[7]", {60'd0, m_arid}, {60'd0, vecs[7].exp_uid});
      check("stream_payload[7]", m_arpayload, vecs[7].payload);
      tick();
      check("stream_drained", {63'd0, m_arvalid}, 64'd0);

      // ---------------- allocator full / stall ----------------
      do_reset();
      m_arready = 1'b1;
      alloc_block = 1'b1; alloc_full = 1'b1;
      s_arvalid = 1'b1; s_arid = 4'h9; s_arpayload = 64'h9999_0000_0000_0009;
      tick();
      s_arid = 4'hA; s_arpayload = 64'hAAAA_0000_0000_000A;
      check("stall_start", {48'd0, stall_cycles}, 64'd0);
      for (int i = 0; i < 10; i++) tick();
      check("stall_10", {48'd0, stall_cycles}, 64'd10);
      check("stall_10_narrow", {60'd0, n_stall_cycles}, 64'd10);
      check("stall_s_arready", {63'd0, s_arready}, 64'd0);
      check("stall_alloc_req", {63'd0, alloc_req}, 64'd1);
      check("stall_orig_id", {60'd0, alloc_orig_id}, 64'd9);
      check("stall_no_out", {63'd0, m_arvalid}, 64'd0);
      for (int i = 0; i < 10; i++) tick();
      check("stall_20", {48'd0, stall_cycles}, 64'd20);
      check("stall_sat_narrow", {60'd0, n_stall_cycles}, 64'hF);
      alloc_block = 1'b0; alloc_full = 1'b0;
      #1;
      check("release_s_arready", {63'd0, s_arready}, 64'd1);
      tick();
      s_arvalid = 1'b0;
      check("release_arid", {60'd0, m_arid}, 64'd0);
      check("release_payload", m_arpayload, 64'h9999_0000_0000_0009);
      check("release_stall_hold", {48'd0, stall_cycles}, 64'd20);
      tick();
      check("release2_arid", {60'd0, m_arid}, 64'd1);
      check("release2_payload", m_arpayload, 64'hAAAA_0000_0000_000A);

      // ---------------- downstream backpressure ----------------
      do_reset();
      m_arready = 1'b0;
      s_arvalid = 1'b1; s_arid = 4'h2; s_arpayload = 64'h2222_2222_2222_2222;
      tick();
      s_arid = 4'h6; s_arpayload = 64'h6666_6666_6666_6666;
      tick();
      s_arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_alloc_req[%0d]", i), {63'd0, alloc_req}, 64'd0);
         check($sformatf("bp_arid[%0d]", i), {60'd0, m_arid}, 64'd0);
         check($sformatf("bp_payload[%0d]", i), m_arpayload, 64'h2222_2222_2222_2222);
         tick();
      end
      check("bp_s_arready", {63'd0, s_arready}, 64'd0);
      check("bp_orig_id", {60'd0, alloc_orig_id}, 64'd6);

      // ---------------- reset with both stages valid ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_m_arvalid", {63'd0, m_arvalid}, 64'd0);
      check("midrst_s_arready", {63'd0, s_arready}, 64'd1);
      check("midrst_alloc_req", {63'd0, alloc_req}, 64'd0);
      check("midrst_stall", {48'd0, stall_cycles}, 64'd0);

      // ---------------- release order after backpressure ----------------
      m_arready = 1'b0;
      s_arvalid = 1'b1; s_arid = 4'h2; s_arpayload = 64'h2222_2222_2222_2222;
      tick();
      s_arid = 4'h6; s_arpayload = 64'h6666_6666_6666_6666;
      tick();
      s_arvalid = 1'b0;
      tick();
      tick();
      m_arready = 1'b1;
      #1;
      check("rel_alloc_req", {63'd0, alloc_req}, 64'd1);
      tick();
      check("rel_arid", {60'd0, m_arid}, 64'd1);
      check("rel_payload", m_arpayload, 64'h6666_6666_6666_6666);
      check("rel_valid", {63'd0, m_arvalid}, 64'd1);
      tick();
      check("rel_drained", {63'd0, m_arvalid}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ar_id_remapper
`default_nettype wire
